tsc_rx: RTL and testbench
=========================

Name: tsc_rx

Overview:
- Receiving end of the tsc buffer-dump link: grants the sender's requestToSend, deserialises framed 32-bit trigger timestamps from sd, and queues them for a downstream consumer.
- Sits beside tsc on the capture board, between the tsc serial output and the host-side readout logic.
- Reports words received per dump, end of dump, and sticky error flags.

Parameters:
- WORD_W, 32, bits per timestamp word; must equal the tsc timer width.
- DEPTH, 8, receive FIFO depth in words; power of two, at least 2.
- CNT_W, 16, width of wordCount.

Ports:
- clk  input  1  single system clock; everything is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- requestToSend  input  1  sender wants to dump its buffer; level held until end of dump.
- sd  input  1  serial data from sender, one bit per clk.
- completeData  input  1  one-cycle pulse from sender marking end of dump.
- clearToSend  output  1  grant to sender; sender may start framing one cycle after it rises.
- wordOut  output  WORD_W  head of receive FIFO.
- wordValid  output  1  FIFO not empty.
- wordReady  input  1  consumer pops the head when wordValid && wordReady.
- wordCount  output  CNT_W  words accepted in the current or last dump; saturates at all-ones.
- dumpDone  output  1  one-cycle pulse at clean or aborted end of dump.
- overflow  output  1  sticky: a completed word was dropped because the FIFO was full.
- frameError  output  1  sticky: a dump was truncated mid-word or aborted.

Behaviour:
- Reset (reset=0, async): state IDLE. clearToSend=0, wordValid=0, wordOut=0, wordCount=0, dumpDone=0, overflow=0, frameError=0. FIFO empty, shift register and bit counter cleared.
- Line format: sd idles low. Each word is a start bit (1) followed by WORD_W data bits, MSB first, one bit per clk, no gap required between words.
- States: IDLE, GRANT, HUNT, SHIFT, DONE.
- IDLE -> GRANT on requestToSend=1. On this entry, clear wordCount, overflow and frameError.
- GRANT: clearToSend=1 is registered, so it rises 1 cycle after requestToSend is sampled. GRANT goes to HUNT unconditionally.
- HUNT, clearToSend=1:
  - sd=1 -> SHIFT, with bit counter set to 0.
  - completeData=1 -> DONE.
  - requestToSend=0 -> DONE and set frameError.
  - If completeData=1 and sd=1 in the same cycle, completeData wins and the start bit is ignored.
- SHIFT:
  - Each cycle: shift = {shift[WORD_W-2:0], sd}, counter++.
  - The cycle that samples bit WORD_W-1 is the last bit. The assembled word, including that bit, is pushed the same cycle, then the state returns to HUNT.
  - Push when full: word dropped, overflow set, wordCount unchanged.
  - Push and pop in the same cycle with FIFO full: both succeed, count unchanged.
  - Each successful push increments wordCount, saturating.
  - completeData=1 or requestToSend=0 during SHIFT: discard the partial word, set frameError, go to DONE. This applies even on the last-bit cycle; the word is not pushed.
- DONE: clearToSend=0 and dumpDone=1 for exactly this cycle, then IDLE. If requestToSend is still 1 in IDLE, a new dump begins (GRANT next cycle).
- FIFO:
  - wordOut and wordValid are registered outputs of FIFO state, not combinational from this cycle's push.
  - A word pushed in cycle n is visible at cycle n+1.
  - Pop is honoured in any state.
  - wordOut holds its last value while empty.
  - Pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.
- Reset mid-dump: all state cleared immediately, FIFO contents lost, clearToSend drops asynchronously.

Decomposition:
- tsc_pkg holds: WORD_W default, state encoding constants (IDLE, GRANT, HUNT, SHIFT, DONE), and the start-bit value.
- One sub-module: tsc_rx_fifo, a parameterised synchronous FIFO (WORD_W, DEPTH) with push/pop/full/empty and the same clk/reset.
- The deserialiser FSM stays in tsc_rx.

Test Plan:
- Reset then requestToSend=1 -> clearToSend=1 exactly 1 cycle later. Outputs at reset values before that.
- Single word: start bit, then 32'hDEADBEEF MSB first, then completeData pulse -> wordOut=32'hDEADBEEF, wordValid=1, wordCount=1, dumpDone one cycle, frameError=0.
- 9 back-to-back words 32'h0000_0001..32'h0000_0009 with wordReady=0, DEPTH=8 -> wordCount=8, overflow=1. Pops return 1..8 in order, then wordValid=0.
- completeData after 17 data bits of 32'hA5A5A5A5 -> no push, frameError=1, dumpDone pulse, wordCount unchanged. A new requestToSend clears frameError.
- Full FIFO with wordReady=1 on the cycle the 9th word completes -> no overflow; 8 words remain, head advances by one.
- Assert reset during SHIFT -> clearToSend=0 and wordValid=0 immediately (asynchronous). After release, a clean single-word dump succeeds.

Source files
------------

// File: rtl/tsc_pkg.sv
// Shared definitions for the tsc buffer-dump link receiver.
//   WORD_W_DEF : default timestamp width (must match the tsc timer width)
//   START_BIT  : line value that opens a word frame (sd idles low)
//   rx_state_e : receiver FSM state encoding
package tsc_pkg;

  localparam int   WORD_W_DEF = 32;
  localparam logic START_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_HUNT  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } rx_state_e;

endpackage

// File: rtl/tsc_rx_fifo.sv
// Synchronous receive FIFO for tsc_rx.
// Head word and valid flag are registered so the consumer never sees a word
// combinationally from the cycle it is written; rd_data holds while empty.
// Ports:
//   clk, reset      : system clock, async active-low reset
//   push, push_data : write request and word
//   pop             : read request (ignored while empty)
//   full, empty     : pointer-derived occupancy flags
//   rd_data         : registered head word
//   rd_valid        : registered not-empty flag
module tsc_rx_fifo #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic              valid_q, valid_d;
  logic              pop_ok, push_ok;

  // Extra pointer bit tells a full ring from an empty one.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d  = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d  = rd_ptr_q + (AW+1)'(pop_ok);
    valid_d   = (wr_ptr_d != rd_ptr_d);
    rd_data_d = rd_data_q;
    if (valid_d) begin
      // Next head is the slot being written right now: bypass the array.
      if (push_ok && (rd_ptr_d == wr_ptr_q)) rd_data_d = push_data;
      else                                   rd_data_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
      valid_q   <= valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = valid_q;

endmodule

// File: rtl/tsc_rx.sv
// Receiving end of the tsc buffer-dump link.
// Grants requestToSend, deserialises start-bit framed words (MSB first) from
// sd and queues them for the host readout.
//
//   state | meaning
//   IDLE  | link quiet, waiting for requestToSend
//   GRANT | clearToSend raised, sender not yet framing
//   HUNT  | waiting for a start bit or end of dump
//   SHIFT | collecting data bits of one word
//   DONE  | one-cycle end-of-dump (dumpDone high, grant dropped)
//
// Ports:
//   clk, reset                : system clock, async active-low reset
//   requestToSend, sd,
//   completeData              : sender side of the link
//   clearToSend               : registered grant back to the sender
//   wordOut, wordValid,
//   wordReady                 : FIFO head to the consumer, pop on valid&ready
//   wordCount                 : words accepted this/last dump, saturating
//   dumpDone                  : one-cycle end-of-dump pulse
//   overflow, frameError      : sticky per-dump error flags
module tsc_rx
  import tsc_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              requestToSend,
  input  logic              sd,
  input  logic              completeData,
  output logic              clearToSend,
  output logic [WORD_W-1:0] wordOut,
  output logic              wordValid,
  input  logic              wordReady,
  output logic [CNT_W-1:0]  wordCount,
  output logic              dumpDone,
  output logic              overflow,
  output logic              frameError
);

  localparam int               BIT_W    = $clog2(WORD_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  rx_state_e         state_q, state_d;
  // MSB of the word is never needed in the register: it leaves on the push.
  logic [WORD_W-2:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;
  logic              overflow_q, overflow_d;
  logic              frame_error_q, frame_error_d;
  logic              cts_q, cts_d;
  logic              dump_done_q, dump_done_d;

  logic [WORD_W-1:0] rx_word;
  logic              push, push_ok;
  logic              fifo_full, fifo_empty;

  assign rx_word = {shift_q, sd};
  assign push_ok = push && (!fifo_full || (wordReady && !fifo_empty));

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    word_count_d  = word_count_q;
    overflow_d    = overflow_q;
    frame_error_d = frame_error_q;
    push          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (requestToSend) begin
          state_d       = ST_GRANT;
          word_count_d  = '0;
          overflow_d    = 1'b0;
          frame_error_d = 1'b0;
        end
      end
      ST_GRANT: state_d = ST_HUNT;
      ST_HUNT: begin
        // End-of-dump outranks a coincident start bit.
        if (completeData) begin
          state_d = ST_DONE;
        end else if (!requestToSend) begin
          state_d       = ST_DONE;
          frame_error_d = 1'b1;
        end else if (sd == START_BIT) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        // Truncation discards the word even on its last bit.
        if (completeData || !requestToSend) begin
          state_d       = ST_DONE;
          frame_error_d = 1'b1;
        end else begin
          shift_d   = rx_word[WORD_W-2:0];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            push    = 1'b1;
            state_d = ST_HUNT;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (push_ok && (word_count_q != '1)) word_count_d = word_count_q + 1'b1;
    if (push && !push_ok)                overflow_d   = 1'b1;

    cts_d       = (state_d == ST_GRANT) || (state_d == ST_HUNT) || (state_d == ST_SHIFT);
    dump_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      word_count_q  <= '0;
      overflow_q    <= 1'b0;
      frame_error_q <= 1'b0;
      cts_q         <= 1'b0;
      dump_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      word_count_q  <= word_count_d;
      overflow_q    <= overflow_d;
      frame_error_q <= frame_error_d;
      cts_q         <= cts_d;
      dump_done_q   <= dump_done_d;
    end
  end

  tsc_rx_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (rx_word),
    .pop       (wordReady),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .rd_data   (wordOut),
    .rd_valid  (wordValid)
  );

  assign clearToSend = cts_q;
  assign wordCount   = word_count_q;
  assign dumpDone    = dump_done_q;
  assign overflow    = overflow_q;
  assign frameError  = frame_error_q;

endmodule

// File: tb/tb_tsc_rx.sv
module tb_tsc_rx;

  localparam int WORD_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              requestToSend;
  logic              sd;
  logic              completeData;
  logic              clearToSend;
  logic [WORD_W-1:0] wordOut;
  logic              wordValid;
  logic              wordReady;
  logic [CNT_W-1:0]  wordCount;
  logic              dumpDone;
  logic              overflow;
  logic              frameError;

  int checks = 0;
  int errors = 0;

  // Reference model: words the consumer should see, plus per-dump status.
  logic [WORD_W-1:0] exp_q [$];
  int                exp_cnt;
  bit                exp_ovf;
  bit                exp_fe;

  tsc_rx #(.WORD_W(WORD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .requestToSend (requestToSend),
    .sd            (sd),
    .completeData  (completeData),
    .clearToSend   (clearToSend),
    .wordOut       (wordOut),
    .wordValid     (wordValid),
    .wordReady     (wordReady),
    .wordCount     (wordCount),
    .dumpDone      (dumpDone),
    .overflow      (overflow),
    .frameError    (frameError)
  );

  always #5 clk = ~clk;

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic model_new_dump();
    exp_cnt = 0;
    exp_ovf = 0;
    exp_fe  = 0;
  endtask

  // One complete word reaches the receiver; an optional pop happens first.
  task automatic model_word(input logic [WORD_W-1:0] w, input bit popped);
    logic [WORD_W-1:0] dummy;
    if (popped && exp_q.size() > 0) dummy = exp_q.pop_front();
    if (exp_q.size() < DEPTH) begin
      exp_q.push_back(w);
      if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
    end else begin
      exp_ovf = 1;
    end
  endtask

  // Raise requestToSend and wait until the receiver is hunting.
  task automatic begin_dump();
    requestToSend = 1'b1;
    @(negedge clk);
    @(negedge clk);
    model_new_dump();
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w, input bit pop_on_last);
    sd = 1'b1;
    @(negedge clk);
    for (int i = WORD_W - 1; i >= 0; i--) begin
      sd = w[i];
      if (i == 0 && pop_on_last) wordReady = 1'b1;
      @(negedge clk);
      wordReady = 1'b0;
    end
    sd = 1'b0;
    model_word(w, pop_on_last);
  endtask

  task automatic send_partial(input logic [WORD_W-1:0] w, input int nbits);
    sd = 1'b1;
    @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sd = w[WORD_W - 1 - i];
      @(negedge clk);
    end
  endtask

  task automatic end_dump(input logic sd_val, output logic pulse, output logic after);
    completeData  = 1'b1;
    requestToSend = 1'b0;
    sd            = sd_val;
    @(negedge clk);
    completeData = 1'b0;
    sd           = 1'b0;
    pulse        = dumpDone;
    @(negedge clk);
    after = dumpDone;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; requestToSend = 1'b0; sd = 1'b0; completeData = 1'b0; wordReady = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({clearToSend, wordValid, dumpDone, overflow, frameError} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000",
               {clearToSend, wordValid, dumpDone, overflow, frameError});
    end
    checks++;
    if (wordOut !== '0 || wordCount !== '0) begin
      errors++;
      $display("FAIL reset_data got word %h count %0d want 0 0", wordOut, wordCount);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    logic p, a;
    requestToSend = 1'b1;
    checks++;
    if (clearToSend !== 1'b0) begin
      errors++; $display("FAIL cts_before got %b want 0", clearToSend);
    end
    @(negedge clk);
    checks++;
    if (clearToSend !== 1'b1) begin
      errors++; $display("FAIL cts_one_cycle got %b want 1", clearToSend);
    end
    @(negedge clk);
    model_new_dump();
    send_word(32'hDEADBEEF, 1'b0);
    end_dump(1'b0, p, a);
    checks++;
    if (wordOut !== 32'hDEADBEEF || wordValid !== 1'b1) begin
      errors++; $display("FAIL single_word got %h v%b want deadbeef v1", wordOut, wordValid);
    end
    checks++;
    if (wordCount !== 16'd1 || frameError !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL single_status got cnt %0d fe %b ovf %b want 1 0 0", wordCount, frameError, overflow);
    end
    checks++;
    if (p !== 1'b1 || a !== 1'b0) begin
      errors++; $display("FAIL single_done got %b%b want 10", p, a);
    end
    wordReady = 1'b1;
    @(negedge clk);
    wordReady = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if (wordValid !== 1'b0 || wordOut !== 32'hDEADBEEF) begin
      errors++; $display("FAIL empty_hold got %h v%b want deadbeef v0", wordOut, wordValid);
    end
  endtask

  task automatic test_overflow();
    logic p, a;
    logic [WORD_W-1:0] w;
    int popped;
    begin_dump();
    for (int k = 1; k <= 9; k++) send_word(WORD_W'(k), 1'b0);
    end_dump(1'b0, p, a);
    checks++;
    if (wordCount !== CNT_W'(exp_cnt) || overflow !== exp_ovf || frameError !== exp_fe) begin
      errors++;
      $display("FAIL ovf_status got cnt %0d ovf %b fe %b want %0d %b %b",
               wordCount, overflow, frameError, exp_cnt, exp_ovf, exp_fe);
    end
    popped = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (wordValid !== 1'b1) break;
      if (exp_q.size() == 0) begin
        checks++; errors++; $display("FAIL ovf_extra got %h want none", wordOut); break;
      end
      w = exp_q.pop_front();
      checks++;
      if (wordOut !== w) begin
        errors++; $display("FAIL ovf_pop got %h want %h", wordOut, w);
      end
      wordReady = 1'b1; @(negedge clk); wordReady = 1'b0;
      popped++;
    end
    checks++;
    if (popped != 8 || wordValid !== 1'b0) begin
      errors++; $display("FAIL ovf_drain got %0d words v%b want 8 v0", popped, wordValid);
    end
  endtask

  task automatic test_truncate();
    logic p, a;
    logic [WORD_W-1:0] w;
    begin_dump();
    send_word(32'h0BAD_F00D, 1'b0);
    send_partial(32'hA5A5A5A5, 17);
    exp_fe = 1;
    end_dump(1'b0, p, a);
    checks++;
    if (frameError !== 1'b1 || wordCount !== 16'd1 || p !== 1'b1 || a !== 1'b0) begin
      errors++;
      $display("FAIL trunc_status got fe %b cnt %0d done %b%b want 1 1 10", frameError, wordCount, p, a);
    end
    w = exp_q.pop_front();
    checks++;
    if (wordOut !== w) begin
      errors++; $display("FAIL trunc_head got %h want %h", wordOut, w);
    end
    wordReady = 1'b1; @(negedge clk); wordReady = 1'b0;
    checks++;
    if (wordValid !== 1'b0) begin
      errors++; $display("FAIL trunc_no_push got v%b want v0", wordValid);
    end
    begin_dump();
    checks++;
    if (frameError !== 1'b0) begin
      errors++; $display("FAIL fe_clear got %b want 0", frameError);
    end
    end_dump(1'b0, p, a);
  endtask

  task automatic test_full_pop();
    logic p, a;
    logic [WORD_W-1:0] w;
    int popped;
    begin_dump();
    for (int k = 1; k <= 8; k++) send_word(WORD_W'(k), 1'b0);
    send_word(WORD_W'(9), 1'b1);
    end_dump(1'b0, p, a);
    checks++;
    if (overflow !== 1'b0 || wordCount !== 16'd9 || wordOut !== 32'd2) begin
      errors++;
      $display("FAIL fullpop_status got ovf %b cnt %0d head %h want 0 9 2", overflow, wordCount, wordOut);
    end
    popped = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (wordValid !== 1'b1) break;
      if (exp_q.size() == 0) begin
        checks++; errors++; $display("FAIL fullpop_extra got %h want none", wordOut); break;
      end
      w = exp_q.pop_front();
      checks++;
      if (wordOut !== w) begin
        errors++; $display("FAIL fullpop_pop got %h want %h", wordOut, w);
      end
      wordReady = 1'b1; @(negedge clk); wordReady = 1'b0;
      popped++;
    end
    checks++;
    if (popped != 8) begin
      errors++; $display("FAIL fullpop_drain got %0d words want 8", popped);
    end
  endtask

  task automatic test_abort_hunt();
    begin_dump();
    requestToSend = 1'b0;
    @(negedge clk);
    checks++;
    if (dumpDone !== 1'b1 || frameError !== 1'b1 || clearToSend !== 1'b0) begin
      errors++;
      $display("FAIL abort_hunt got done %b fe %b cts %b want 1 1 0", dumpDone, frameError, clearToSend);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic p, a;
    logic [WORD_W-1:0] w;
    begin_dump();
    send_word(32'h1234_5678, 1'b0);
    send_partial(32'hFFFF_0000, 5);
    checks++;
    if (wordValid !== 1'b1 || clearToSend !== 1'b1) begin
      errors++; $display("FAIL pre_reset got v%b cts %b want v1 1", wordValid, clearToSend);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (clearToSend !== 1'b0 || wordValid !== 1'b0) begin
      errors++; $display("FAIL async_reset got cts %b v%b want 0 0", clearToSend, wordValid);
    end
    exp_q.delete();
    requestToSend = 1'b0; sd = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    w = $urandom;
    begin_dump();
    send_word(w, 1'b0);
    end_dump(1'b0, p, a);
    checks++;
    if (wordOut !== w || wordValid !== 1'b1 || wordCount !== 16'd1 || frameError !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got %h v%b cnt %0d fe %b want %h v1 1 0", wordOut, wordValid, wordCount, frameError, w);
    end
    wordReady = 1'b1; @(negedge clk); wordReady = 1'b0;
    void'(exp_q.pop_front());
  endtask

  task automatic test_random();
    logic p, a;
    logic [WORD_W-1:0] w;
    int n, tbits;
    bit trunc;
    for (int it = 0; it < 8; it++) begin
      n     = $urandom_range(1, 11);
      trunc = ($urandom_range(0, 2) == 0);
      tbits = $urandom_range(0, 31);
      begin_dump();
      for (int k = 0; k < n; k++) send_word($urandom, 1'b0);
      if (trunc) begin
        w = $urandom;
        send_partial(w, tbits);
        exp_fe = 1;
        end_dump(w[WORD_W - 1 - tbits], p, a);
      end else begin
        // sd may be a start bit here; end-of-dump must still win cleanly.
        end_dump(1'($urandom_range(0, 1)), p, a);
      end
      checks++;
      if (wordCount !== CNT_W'(exp_cnt) || overflow !== exp_ovf || frameError !== exp_fe) begin
        errors++;
        $display("FAIL rand_status it %0d got cnt %0d ovf %b fe %b want %0d %b %b",
                 it, wordCount, overflow, frameError, exp_cnt, exp_ovf, exp_fe);
      end
      checks++;
      if (p !== 1'b1 || a !== 1'b0) begin
        errors++; $display("FAIL rand_done it %0d got %b%b want 10", it, p, a);
      end
      for (int i = 0; i < DEPTH + 4; i++) begin
        if (wordValid !== 1'b1) break;
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL rand_extra got %h want none", wordOut); break;
        end
        w = exp_q.pop_front();
        checks++;
        if (wordOut !== w) begin
          errors++; $display("FAIL rand_pop it %0d got %h want %h", it, wordOut, w);
        end
        wordReady = 1'b1; @(negedge clk); wordReady = 1'b0;
      end
      checks++;
      if (exp_q.size() != 0 || wordValid !== 1'b0) begin
        errors++;
        $display("FAIL rand_drain it %0d got %0d undelivered v%b want 0 v0", it, exp_q.size(), wordValid);
        exp_q.delete();
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_overflow();
    test_truncate();
    test_full_pop();
    test_abort_hunt();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
